// File: rtl/physical_oserdes_tx_trainer.sv
// rtl/physical_oserdes_tx_trainer.sv - OSERDES transmit link trainer (train burst, sync marker, lock wait, data)
// Optional PRBS7 training pattern selected by macro TX_TRAIN_PRBS_EN.
module physical_oserdes_tx_trainer #(
  parameter int SERDES_WIDTH    = 4,
  parameter int TRAIN_CNT_WIDTH = 6,
  parameter int TIMEOUT_WIDTH   = 12,
  parameter logic [SERDES_WIDTH-1:0] SYNC_WORD = 4'b1100,
  parameter logic [SERDES_WIDTH-1:0] IDLE_WORD = 4'b0000
) (
  input  logic                    i_clk,
  input  logic                    local_arst_n,
  input  logic                    i_enable,
  input  logic                    i_remote_locked,
  input  logic [SERDES_WIDTH-1:0] i_data,
  input  logic                    i_data_valid,
  output logic                    o_data_ready,
  output logic [SERDES_WIDTH-1:0] o_serdes,
  output logic                    o_training,
  output logic                    o_link_up,
  output logic                    o_fail
);

  typedef enum logic [5:0] {
    S_IDLE      = 6'b000001,
    S_TRAIN     = 6'b000010,
    S_SYNC      = 6'b000100,
    S_WAIT_LOCK = 6'b001000,
    S_DATA      = 6'b010000,
    S_FAIL      = 6'b100000
  } state_t;

  localparam logic [TRAIN_CNT_WIDTH-1:0] SYNC_LAST = TRAIN_CNT_WIDTH'(3);

  state_t                    r_state;
  state_t                    w_next;
  logic [TRAIN_CNT_WIDTH-1:0] r_burst_cnt;
  logic [TIMEOUT_WIDTH-1:0]  r_timeout_cnt;
  logic [SERDES_WIDTH-1:0]   r_serdes;
  logic                      r_training;
  logic [SERDES_WIDTH-1:0]   w_word;
  logic                      w_train_flag;
  logic [SERDES_WIDTH-1:0]   w_train_word;

`ifdef TX_TRAIN_PRBS_EN
  logic [6:0]              r_prbs;
  logic [6:0]              w_prbs_next;
  logic [SERDES_WIDTH-1:0] w_prbs_word;

  // x^7+x^6+1, SERDES_WIDTH bits shifted out per cycle, MSB of the word first
  always_comb begin
    w_prbs_next = r_prbs;
    w_prbs_word = '0;
    for (int i = SERDES_WIDTH - 1; i >= 0; i--) begin
      w_prbs_word[i] = w_prbs_next[6];
      w_prbs_next    = {w_prbs_next[5:0], w_prbs_next[6] ^ w_prbs_next[5]};
    end
  end

  always_ff @(posedge i_clk or negedge local_arst_n) begin
    if (!local_arst_n) begin
      r_prbs <= 7'h7F;
    end else if (r_state == S_IDLE) begin
      r_prbs <= 7'h7F;
    end else if (r_state == S_TRAIN || r_state == S_WAIT_LOCK) begin
      r_prbs <= w_prbs_next;
    end
  end

  assign w_train_word = w_prbs_word;
`else
  localparam logic [SERDES_WIDTH-1:0] TRAIN_WORD = {(SERDES_WIDTH/2){2'b10}};
  assign w_train_word = TRAIN_WORD;
`endif

  always_ff @(posedge i_clk or negedge local_arst_n) begin
    if (!local_arst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (i_enable) w_next = S_TRAIN;
      S_TRAIN:     if (r_burst_cnt == '1) w_next = S_SYNC;
      S_SYNC:      if (r_burst_cnt == SYNC_LAST) w_next = S_WAIT_LOCK;
      // lock takes priority over a timeout landing in the same cycle
      S_WAIT_LOCK: begin
        if (i_remote_locked) w_next = S_DATA;
        else if (r_timeout_cnt == '1) w_next = S_FAIL;
      end
      S_DATA:      if (!i_remote_locked) w_next = S_TRAIN;
      S_FAIL:      w_next = S_FAIL;
      default:     w_next = S_IDLE;
    endcase
    if (!i_enable) w_next = S_IDLE;
  end

  // Counters restart on every state change and saturate rather than wrap
  always_ff @(posedge i_clk or negedge local_arst_n) begin
    if (!local_arst_n) begin
      r_burst_cnt   <= '0;
      r_timeout_cnt <= '0;
    end else if (w_next != r_state) begin
      r_burst_cnt   <= '0;
      r_timeout_cnt <= '0;
    end else begin
      if ((r_state == S_TRAIN || r_state == S_SYNC) && r_burst_cnt != '1)
        r_burst_cnt <= r_burst_cnt + 1'b1;
      if (r_state == S_WAIT_LOCK && r_timeout_cnt != '1)
        r_timeout_cnt <= r_timeout_cnt + 1'b1;
    end
  end

  always_comb begin
    w_word       = IDLE_WORD;
    w_train_flag = 1'b0;
    case (r_state)
      S_TRAIN, S_WAIT_LOCK: begin
        w_word       = w_train_word;
        w_train_flag = 1'b1;
      end
      S_SYNC: begin
        w_word       = SYNC_WORD;
        w_train_flag = 1'b1;
      end
      S_DATA:  if (i_data_valid) w_word = i_data;
      default: w_word = IDLE_WORD;
    endcase
  end

  always_ff @(posedge i_clk or negedge local_arst_n) begin
    if (!local_arst_n) begin
      r_serdes   <= '0;
      r_training <= 1'b0;
    end else begin
      r_serdes   <= w_word;
      r_training <= w_train_flag;
    end
  end

  assign o_serdes     = r_serdes;
  assign o_training   = r_training;
  assign o_data_ready = (r_state == S_DATA);
  assign o_link_up    = (r_state == S_DATA);
  assign o_fail       = (r_state == S_FAIL);

endmodule

// File: tb/tb_physical_oserdes_tx_trainer.sv
// tb/tb_physical_oserdes_tx_trainer.sv - self-checking bench for physical_oserdes_tx_trainer
// Expected words come from a phase-level model of the link bring-up sequence.
module tb_physical_oserdes_tx_trainer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         enable;
  logic         lock;
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic [W-1:0] serdes;
  logic         training;
  logic         link_up;
  logic         fail;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  physical_oserdes_tx_trainer #(
    .SERDES_WIDTH(W),
    .TRAIN_CNT_WIDTH(6),
    .TIMEOUT_WIDTH(4),
    .SYNC_WORD(4'b1100),
    .IDLE_WORD(4'b0000)
  ) dut (
    .i_clk(clk),
    .local_arst_n(arst_n),
    .i_enable(enable),
    .i_remote_locked(lock),
    .i_data(data),
    .i_data_valid(valid),
    .o_data_ready(ready),
    .o_serdes(serdes),
    .o_training(training),
    .o_link_up(link_up),
    .o_fail(fail)
  );

`ifdef TX_TRAIN_PRBS_EN
  logic [6:0] m_prbs = 7'h7F;
  task automatic next_train(output logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      w[i]   = m_prbs[6];
      m_prbs = {m_prbs[5:0], m_prbs[6] ^ m_prbs[5]};
    end
  endtask
  task automatic reseed();
    m_prbs = 7'h7F;
  endtask
`else
  task automatic next_train(output logic [W-1:0] w);
    w = {(W/2){2'b10}};
  endtask
  task automatic reseed();
  endtask
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int idx, input logic [W-1:0] s,
                       input logic tr, input logic lk, input logic fl);
    logic [W+3:0] obs;
    logic [W+3:0] exp;
    obs = {serdes, training, link_up, ready, fail};
    exp = {s, tr, lk, lk, fl};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed={serdes,trn,link,rdy,fail}=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  task automatic idle_cycle(input string tag);
    tick();
    check(tag, 0, 4'h0, 1'b0, 1'b0, 1'b0);
    reseed();
  endtask

  task automatic train_words(input string tag, input int n);
    logic [W-1:0] w;
    for (int i = 0; i < n; i++) begin
      tick();
      next_train(w);
      check(tag, i, w, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic train_sync(input string tag);
    train_words({tag, "_train"}, 64);
    for (int i = 0; i < 4; i++) begin
      tick();
      check({tag, "_sync"}, i, 4'b1100, 1'b1, 1'b0, 1'b0);
    end
  endtask

  // lock sampled during the k-th cycle of the lock wait
  task automatic wait_lock(input string tag, input int k);
    logic [W-1:0] w;
    for (int i = 1; i <= k; i++) begin
      if (i == k) lock = 1'b1;
      tick();
      next_train(w);
      check(tag, i, w, 1'b1, (i == k), 1'b0);
    end
  endtask

  task automatic data_phase(input string tag, input int n);
    logic [W-1:0] d;
    logic         v;
    for (int i = 0; i < n; i++) begin
      v = 1'($urandom_range(0, 1));
      d = 4'($urandom);
      valid = v;
      data  = d;
      tick();
      check(tag, i, v ? d : 4'h0, 1'b0, 1'b1, 1'b0);
    end
    valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] d;
    logic         v;
    logic [W-1:0] w;
    arst_n = 1'b0;
    enable = 1'b0;
    lock   = 1'b0;
    valid  = 1'b0;
    data   = '0;

    #2;
    check("reset", 0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check("reset", 1, 4'h0, 1'b0, 1'b0, 1'b0);
    arst_n = 1'b1;
    tick();
    check("idle_disabled", 0, 4'h0, 1'b0, 1'b0, 1'b0);

    // bring-up, lock on 10th wait cycle, directed data words
    enable = 1'b1;
    idle_cycle("start");
    train_sync("burst1");
    wait_lock("lock10", 10);
    valid = 1'b1;
    data  = 4'h5;
    tick();
    check("data5", 0, 4'h5, 1'b0, 1'b1, 1'b0);
    valid = 1'b0;
    tick();
    check("data_none", 0, 4'h0, 1'b0, 1'b1, 1'b0);
    data_phase("data_rand1", 20);

    // retrain on lock drop; the word offered in the drop cycle is still taken
    lock  = 1'b0;
    v     = 1'b1;
    d     = 4'($urandom);
    valid = v;
    data  = d;
    tick();
    check("lock_drop", 0, d, 1'b0, 1'b0, 1'b0);
    valid = 1'b0;
    train_sync("retrain");
    wait_lock("lock_rand", int'($urandom_range(1, 16)));
    data_phase("data_rand2", 10);

    // enable low from the data phase
    enable = 1'b0;
    v      = 1'($urandom_range(0, 1));
    d      = 4'($urandom);
    valid  = v;
    data   = d;
    tick();
    check("disable_data", 0, v ? d : 4'h0, 1'b0, 1'b0, 1'b0);
    valid = 1'b0;
    lock  = 1'b0;
    tick();
    check("disable_idle", 0, 4'h0, 1'b0, 1'b0, 1'b0);

    // lock never arrives: fail after 16 wait cycles, cleared by enable low
    enable = 1'b1;
    idle_cycle("restart_fail");
    train_sync("burst_fail");
    for (int i = 1; i <= 16; i++) begin
      tick();
      next_train(w);
      check("timeout_wait", i, w, 1'b1, 1'b0, (i == 16));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fail_hold", i, 4'h0, 1'b0, 1'b0, 1'b1);
    end
    enable = 1'b0;
    tick();
    check("fail_clear", 0, 4'h0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset in the middle of a training burst
    enable = 1'b1;
    idle_cycle("restart_rst");
    train_words("burst_partial", int'($urandom_range(3, 40)));
    arst_n = 1'b0;
    #1;
    check("mid_reset", 0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check("mid_reset", 1, 4'h0, 1'b0, 1'b0, 1'b0);
    arst_n = 1'b1;
    idle_cycle("post_reset");
    train_sync("burst_after_rst");

    // lock arriving exactly as the timeout expires wins
    wait_lock("lock16", 16);
    data_phase("data_rand3", 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
